// File: rtl/jpeg_pkg.sv
// Shared definitions for the JPEG entropy-coder output path: packer FSM
// state encodings, byte constants used by the stuffing logic, and the
// width of the code-length field.
package jpeg_pkg;

  localparam int CODE_LEN_W = 6;

  // Packer FSM encodings (kept as plain constants for legacy tools).
  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_PAD   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [1:0] bsw_state_t;

  localparam logic [7:0] JPEG_STUFF_BYTE    = 8'h00;
  localparam logic [7:0] JPEG_MARKER_PREFIX = 8'hFF;

  // A data byte equal to the marker prefix must be followed by a stuff byte
  // so the decoder never mistakes entropy data for a marker.
  function automatic logic is_marker_prefix(input logic [7:0] b);
    return (b == JPEG_MARKER_PREFIX);
  endfunction

endpackage

// File: rtl/jpeg_bsw_out_slot.sv
// Output byte register for the bitstream writer. Holds one byte under
// valid/ready, takes new data from the accumulator when the slot frees up,
// and inserts a 0x00 stuff byte after every 0xFF it has emitted.
//
// Handshake: a byte transfers on a clock edge where byte_valid_o and
// byte_ready_i are both high; while byte_valid_o is high and byte_ready_i is
// low, byte_out_o and byte_valid_o hold their values.
module jpeg_bsw_out_slot
  import jpeg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_avail_i,    // accumulator holds a full byte
  input  logic [7:0] data_i,          // top byte of the accumulator
  input  logic       clear_stuff_i,   // end-of-scan clean-up
  input  logic       byte_ready_i,
  output logic       data_take_o,     // accumulator byte consumed this cycle
  output logic       slot_free_o,
  output logic       stuff_pending_o,
  output logic [7:0] byte_out_o,
  output logic       byte_valid_o
);

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       stuff_q, stuff_d;

  assign slot_free_o     = !valid_q || byte_ready_i;
  // Stuffing has priority, so no accumulator byte is taken while it waits.
  assign data_take_o     = slot_free_o && !stuff_q && data_avail_i;
  assign stuff_pending_o = stuff_q;
  assign byte_out_o      = data_q;
  assign byte_valid_o    = valid_q;

  // Next-state selection: stuff byte first, then accumulator data, else empty.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    stuff_d = stuff_q;
    if (slot_free_o) begin
      if (stuff_q) begin
        data_d  = JPEG_STUFF_BYTE;
        valid_d = 1'b1;
        stuff_d = 1'b0;
      end else if (data_avail_i) begin
        data_d  = data_i;
        valid_d = 1'b1;
        stuff_d = is_marker_prefix(data_i);
      end else begin
        valid_d = 1'b0;
      end
    end
    if (clear_stuff_i) begin
      stuff_d = 1'b0;
    end
  end

  // Slot registers; reset drops byte_valid immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      stuff_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      stuff_q <= stuff_d;
    end
  end

endmodule

// File: rtl/jpeg_bitstream_writer.sv
// JPEG entropy-coder bit packer. Appends variable-length code words (MSB
// first) into an MSB-aligned accumulator and emits bytes with 0xFF/0x00
// stuffing. A beat with code_last pads the final partial byte with 1s,
// drains everything and pulses flush_done.
//
// Optional: define JPEG_BSW_BYTE_COUNT_EN to add the byte_count output, a
// count of all accepted output bytes (stuff bytes included) that clears at
// the end of each flushed scan.
//
// Input handshake: a beat transfers on a clock edge where code_valid and
// code_ready are both high. code_ready is registered and only asserted when
// a maximum-length code is guaranteed to fit.
module jpeg_bitstream_writer
  import jpeg_pkg::*;
#(
  parameter int MAX_CODE_LEN = 32,
  parameter int ACC_W        = 40
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MAX_CODE_LEN-1:0] code_bits,
  input  logic [CODE_LEN_W-1:0]   code_len,
  input  logic                    code_last,
  input  logic                    code_valid,
  output logic                    code_ready,
  output logic [7:0]              byte_out,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    flush_done,
`ifdef JPEG_BSW_BYTE_COUNT_EN
  output logic [31:0]             byte_count,
`endif
  output logic [1:0]              dbg_state
);

  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam logic [FILL_W-1:0] FILL_BYTE  = FILL_W'(8);
  localparam logic [FILL_W-1:0] FILL_ROUND = FILL_W'(7);
  // Largest fill at which a MAX_CODE_LEN word still fits.
  localparam logic [FILL_W-1:0] FILL_LIMIT = FILL_W'(ACC_W - MAX_CODE_LEN);

  bsw_state_t        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              code_ready_q, code_ready_d;

  logic              accept;
  logic [FILL_W-1:0] len_c;
  logic [ACC_W-1:0]  code_aligned;
  logic [ACC_W-1:0]  ins_bits;
  logic [ACC_W-1:0]  acc_shift;
  logic [FILL_W-1:0] fill_base;
  logic [FILL_W-1:0] fill_round;
  logic [ACC_W-1:0]  pad_mask;

  logic              data_avail;
  logic              data_take;
  logic              slot_free;
  logic              stuff_pending;
  logic              clear_stuff;

  assign accept      = code_valid && code_ready_q;
  assign code_ready  = code_ready_q;
  assign flush_done  = (state_q == S_DONE);
  assign clear_stuff = (state_q == S_DONE);
  assign dbg_state   = state_q;

  // Clamp oversize lengths; left-justify the code so bits at or above the
  // length fall off the top, then drop it just below the current fill.
  always_comb begin
    if (int'(code_len) > MAX_CODE_LEN) begin
      len_c = FILL_W'(MAX_CODE_LEN);
    end else begin
      len_c = FILL_W'(code_len);
    end
    code_aligned = {{(ACC_W-MAX_CODE_LEN){1'b0}}, code_bits} << (ACC_W - int'(len_c));
    ins_bits     = code_aligned >> fill_base;
  end

  // Accumulator bytes are only offered while running or draining; the pad
  // cycle rewrites the low bits and must not race a byte pop.
  assign data_avail = ((state_q == S_RUN) || (state_q == S_DRAIN)) && (fill_q >= FILL_BYTE);
  assign acc_shift  = data_take ? (acc_q << 8) : acc_q;
  assign fill_base  = data_take ? (fill_q - FILL_BYTE) : fill_q;

  // Pad with 1s from the current fill up to the next byte boundary.
  assign fill_round = (fill_q + FILL_ROUND) & ~FILL_ROUND;
  assign pad_mask   = ({ACC_W{1'b1}} >> fill_q) & ~({ACC_W{1'b1}} >> fill_round);

  // Packer FSM and accumulator next state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_shift;
    fill_d  = fill_base;
    case (state_q)
      S_RUN: begin
        if (accept) begin
          acc_d  = acc_shift | ins_bits;
          fill_d = fill_base + len_c;
          if (code_last) begin
            state_d = S_PAD;
          end
        end
      end
      S_PAD: begin
        acc_d   = acc_q | pad_mask;
        fill_d  = fill_round;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((fill_q == '0) && !stuff_pending && slot_free) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_RUN;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
    code_ready_d = (state_d == S_RUN) && (fill_d <= FILL_LIMIT);
  end

  // State, accumulator and registered ready decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_RUN;
      acc_q        <= '0;
      fill_q       <= '0;
      code_ready_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      fill_q       <= fill_d;
      code_ready_q <= code_ready_d;
    end
  end

  jpeg_bsw_out_slot u_out_slot (
    .clk             (clk),
    .rst_n           (rst_n),
    .data_avail_i    (data_avail),
    .data_i          (acc_q[ACC_W-1 -: 8]),
    .clear_stuff_i   (clear_stuff),
    .byte_ready_i    (byte_ready),
    .data_take_o     (data_take),
    .slot_free_o     (slot_free),
    .stuff_pending_o (stuff_pending),
    .byte_out_o      (byte_out),
    .byte_valid_o    (byte_valid)
  );

`ifdef JPEG_BSW_BYTE_COUNT_EN
  logic [31:0] byte_count_q;

  // Count every transferred output byte; restart at the end of each scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_count_q <= 32'd0;
    end else if (state_q == S_DONE) begin
      byte_count_q <= 32'd0;
    end else if (byte_valid && byte_ready) begin
      byte_count_q <= byte_count_q + 32'd1;
    end
  end

  assign byte_count = byte_count_q;
`endif

endmodule

// File: tb/tb_jpeg_bitstream_writer.sv
// Testbench for jpeg_bitstream_writer: table of flushed scans with hand
// computed bytes, hand sequences for flush timing / stall / reset, and a
// byte scoreboard fed either by the table or by a bit-level packer model.
module tb_jpeg_bitstream_writer;

  logic        clk;
  logic        rst_n;
  logic [31:0] code_bits;
  logic [5:0]  code_len;
  logic        code_last;
  logic        code_valid;
  logic        code_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        flush_done;
  logic [1:0]  dbg_state;
`ifdef JPEG_BSW_BYTE_COUNT_EN
  logic [31:0] byte_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int flush_cnt = 0;
  logic flush_prev = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] m_acc = 8'h00;
  int         m_cnt = 0;

  jpeg_bitstream_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_bits  (code_bits),
    .code_len   (code_len),
    .code_last  (code_last),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush_done (flush_done),
`ifdef JPEG_BSW_BYTE_COUNT_EN
    .byte_count (byte_count),
`endif
    .dbg_state  (dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference packer model: bits MSB first, stuffing after 0xFF, 1-padding.
  task automatic model_bit(input logic b);
    m_acc = {m_acc[6:0], b};
    m_cnt++;
    if (m_cnt == 8) begin
      exp_q.push_back(m_acc);
      if (m_acc == 8'hFF) exp_q.push_back(8'h00);
      m_cnt = 0;
    end
  endtask

  task automatic model_push(input logic [31:0] bits, input logic [5:0] len, input logic last);
    int n;
    n = (int'(len) > 32) ? 32 : int'(len);
    for (int i = n - 1; i >= 0; i--) model_bit(bits[i]);
    if (last) begin
      while (m_cnt != 0) model_bit(1'b1);
    end
  endtask

  // Driver: present a beat, hold until accepted (bounded).
  task automatic send(input logic [31:0] bits, input logic [5:0] len, input logic last,
                      input bit use_model);
    int waited;
    bit timed_out;
    waited = 0;
    timed_out = 1'b0;
    code_bits  = bits;
    code_len   = len;
    code_last  = last;
    code_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (code_ready) break;
      waited++;
      if (waited > 300) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_accept: got no code_ready, required accept within 300 cycles");
      code_valid = 1'b0;
      code_last  = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      code_valid = 1'b0;
      code_last  = 1'b0;
      if (use_model) model_push(bits, len, last);
    end
  endtask

  task automatic wait_flush(input string name);
    int start;
    int c;
    start = flush_cnt;
    c = 0;
    while (flush_cnt == start && c < 300) begin
      @(negedge clk);
      #1;
      c++;
    end
    n_checks++;
    if (flush_cnt == start) begin
      n_fail++;
      $display("FAIL %s: got no flush_done, required pulse within 300 cycles", name);
    end
  endtask

  // Scoreboard: compare every transferred byte; watch flush_done width.
  always @(negedge clk) begin
    if (rst_n && byte_valid && byte_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL byte_unexpected: got %02h, required no byte", byte_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (byte_out !== e) begin
          n_fail++;
          $display("FAIL byte_data: got %02h, required %02h", byte_out, e);
        end
      end
    end
    if (rst_n && flush_done) begin
      flush_cnt++;
      n_checks++;
      if (flush_prev) begin
        n_fail++;
        $display("FAIL flush_done_width: got 2+ cycles, required 1 cycle");
      end
    end
    flush_prev = flush_done;
  end

  typedef struct {
    logic [31:0] b1;
    logic [5:0]  l1;
    logic [31:0] b2;
    logic [5:0]  l2;
    int          nexp;
    logic [47:0] exp_bytes;
  } vec_t;

  vec_t vecs[7];

  initial begin
    // Table of scans: beat 1, then beat 2 with code_last; expected bytes MSB first.
    vecs[0] = '{32'h5,        6'd3,  32'h1F, 6'd5, 1, 48'hBF00_0000_0000};
    vecs[1] = '{32'hFF,       6'd8,  32'h12, 6'd8, 3, 48'hFF00_1200_0000};
    vecs[2] = '{32'h0,        6'd0,  32'h2,  6'd3, 1, 48'h5F00_0000_0000};
    vecs[3] = '{32'h0,        6'd0,  32'hF,  6'd4, 2, 48'hFF00_0000_0000};
    vecs[4] = '{32'hFFFF_FFA5, 6'd8, 32'h0,  6'd0, 1, 48'hA500_0000_0000};
    vecs[5] = '{32'h1234_5678, 6'd63, 32'h1, 6'd1, 6, 48'h1234_5678_FF00};
    vecs[6] = '{32'h3FF,      6'd10, 32'h0,  6'd2, 3, 48'hFF00_CF00_0000};

    code_bits  = '0;
    code_len   = '0;
    code_last  = 1'b0;
    code_valid = 1'b0;
    byte_ready = 1'b1;
    rst_n      = 1'b0;

    // Reset values
    #1;
    check("rst_code_ready", 64'(code_ready), 64'd0);
    check("rst_byte_valid", 64'(byte_valid), 64'd0);
    check("rst_byte_out",   64'(byte_out),   64'h00);
    check("rst_flush_done", 64'(flush_done), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(code_ready), 64'd1);
    check("state_after_reset", 64'(dbg_state), 64'd0);

    // Table-driven flushed scans
    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < vecs[i].nexp; k++) begin
        exp_q.push_back(vecs[i].exp_bytes[47-8*k -: 8]);
      end
      send(vecs[i].b1, vecs[i].l1, 1'b0, 1'b0);
      send(vecs[i].b2, vecs[i].l2, 1'b1, 1'b0);
      wait_flush($sformatf("vec%0d_flush", i));
      check($sformatf("vec%0d_drained", i), 64'(exp_q.size()), 64'd0);
`ifdef JPEG_BSW_BYTE_COUNT_EN
      check($sformatf("vec%0d_count_clear", i), 64'(byte_count), 64'd0);
`endif
      @(negedge clk);
      #1;
      check($sformatf("vec%0d_ready_back", i), 64'(code_ready), 64'd1);
      @(posedge clk);
      #1;
    end

    // flush_done timing: pulse in the cycle right after the last byte transfers
    begin : flush_timing
      int c;
      bit got;
      exp_q.push_back(8'h5F);
      send(32'h2, 6'd3, 1'b1, 1'b0);
      c = 0;
      got = 1'b0;
      while (c < 50) begin
        @(negedge clk);
        if (byte_valid) begin
          got = 1'b1;
          break;
        end
        c++;
      end
      check("ft_byte_seen", 64'(got), 64'd1);
      check("ft_no_early_done", 64'(flush_done), 64'd0);
      @(negedge clk);
      check("ft_done_pulse", 64'(flush_done), 64'd1);
      @(negedge clk);
      check("ft_done_low", 64'(flush_done), 64'd0);
      check("ft_ready_back", 64'(code_ready), 64'd1);
      @(posedge clk);
      #1;
    end

    // Empty flush: nothing emitted, flush_done two cycles after the accept
    send(32'h0, 6'd0, 1'b1, 1'b0);
    @(negedge clk);
    check("empty_done_c0", 64'(flush_done), 64'd0);
    @(negedge clk);
    check("empty_done_c1", 64'(flush_done), 64'd0);
    @(negedge clk);
    check("empty_done_c2", 64'(flush_done), 64'd1);
    check("empty_no_bytes", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Backpressure: byte_ready low for 12 cycles while 20 random codes stream
    byte_ready = 1'b0;
    fork
      begin : hold_side
        logic [7:0] held;
        bit have;
        bit saw_low;
        have = 1'b0;
        saw_low = 1'b0;
        held = 8'h00;
        for (int c = 0; c < 12; c++) begin
          @(negedge clk);
          if (byte_valid) begin
            if (!have) begin
              held = byte_out;
              have = 1'b1;
            end else begin
              check("stall_byte_stable", 64'(byte_out), 64'(held));
            end
          end
          if (!code_ready) saw_low = 1'b1;
        end
        check("stall_valid_held", 64'(have), 64'd1);
        check("stall_ready_drop", 64'(saw_low), 64'd1);
        @(posedge clk);
        #1;
        byte_ready = 1'b1;
      end
      begin : stream_side
        for (int i = 0; i < 20; i++) begin
          logic [5:0] l;
          l = (i == 0) ? 6'd32 : 6'($urandom_range(0, 32));
          send($urandom, l, (i == 19), 1'b1);
        end
      end
    join
    wait_flush("stall_flush");
    check("stall_drained", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // Reset mid-stream with a byte held in the output slot
    byte_ready = 1'b0;
    send(32'h77, 6'd8, 1'b0, 1'b0);
    send(32'h33, 6'd8, 1'b0, 1'b0);
    begin : wait_valid
      int c;
      c = 0;
      while (!byte_valid && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    check("pre_reset_valid", 64'(byte_valid), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_byte_valid", 64'(byte_valid), 64'd0);
    check("midrst_code_ready", 64'(code_ready), 64'd0);
    check("midrst_byte_out",   64'(byte_out),   64'h00);
    @(negedge clk);
    rst_n = 1'b1;
    byte_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(8'hA5);
    send(32'hA5, 6'd8, 1'b0, 1'b0);
    send(32'h0, 6'd0, 1'b1, 1'b0);
    wait_flush("post_reset_flush");
    check("post_reset_drained", 64'(exp_q.size()), 64'd0);
    repeat (4) @(posedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/jpeg_bitstream_writer.md
Name: jpeg_bitstream_writer

Overview:
Entropy-coder output packer for the JPEG encoder path; the transmit-side counterpart of the decoder's bit reader.
- Accepts variable-length code words (Huffman code plus appended magnitude bits), MSB first, and packs them into an 8-bit byte stream.
- Inserts a 0x00 stuffing byte after every emitted 0xFF.
- On a final flush, pads the last partial byte with 1s.
- Sits between the Huffman encoder and the JFIF byte/marker multiplexer.

Parameters:
- MAX_CODE_LEN, 32, maximum bits per input code word; code_bits width.
- ACC_W, 40, bit accumulator width; must be >= MAX_CODE_LEN + 8.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- code_bits  in  MAX_CODE_LEN  code word, right-justified; bits at or above code_len are ignored
- code_len  in  6  number of valid bits, 0..MAX_CODE_LEN
- code_last  in  1  final beat of scan; triggers pad/flush after this beat's bits
- code_valid  in  1  input beat valid
- code_ready  out  1  input beat accepted when code_valid && code_ready
- byte_out  out  8  output byte
- byte_valid  out  1  byte_out valid
- byte_ready  in  1  downstream accepts on byte_valid && byte_ready
- flush_done  out  1  one-cycle pulse after the last byte of a flushed scan is accepted

Behaviour:
Clock and reset:
- Single clock domain (clk). Reset is asynchronous, active-low (rst_n).
- Reset values: code_ready=0, byte_valid=0, byte_out=0x00, flush_done=0. Accumulator, fill count and stuff flag are cleared; state is S_RUN.
- code_ready rises on the first clock edge after reset release.
- Assertion of rst_n mid-operation discards all buffered bits with no partial output. A byte_valid that was high drops immediately (async).

Accumulator:
- MSB-aligned; fill counter is 0..ACC_W.
- On acceptance, masked code_bits are appended below the existing fill, MSB first; fill += code_len.
- code_len=0 is accepted with no bit change. code_len > MAX_CODE_LEN is clamped to MAX_CODE_LEN.
- code_ready = (state==S_RUN) && (fill_next_free >= MAX_CODE_LEN). This is a registered decision, conservative so that any legal length fits.

Output register:
- Loaded when the slot is free (!byte_valid || byte_ready).
- If stuff_pending is set, the slot loads 0x00 and clears stuff_pending; no accumulator bits are consumed.
- Otherwise, if fill >= 8, the slot loads the top 8 bits and fill -= 8. If the loaded byte is 0xFF, stuff_pending is set.
- Stuffing always takes priority over new data bytes.
- Simultaneous accept and byte pop in one cycle are legal; the fill update is fill + len - 8.

Latency:
- A beat accepted at edge E updates the accumulator at E.
- The first full byte is loaded into the output register at E+1, so byte_valid is high after E+1.
- Sustained throughput is one byte per cycle; stuff bytes take one extra slot each.

State machine:
- S_RUN: normal packing. Accepting a beat with code_last=1 -> S_PAD. code_ready=0 from that edge onward.
- S_PAD: if fill mod 8 != 0, fill the low bits of the partial byte with 1s and round fill up to a multiple of 8 (one cycle). -> S_DRAIN.
- S_DRAIN: emit the remaining bytes and stuffing as normal. When fill==0, !stuff_pending and the last byte is accepted -> S_DONE.
- S_DONE: flush_done=1 for one cycle; clears the stuff flag. -> S_RUN.

Boundary conditions:
- A flush with fill already byte-aligned adds no pad bits.
- A flush with fill==0 emits nothing; flush_done pulses 2 cycles after the accept.
- Padding that produces 0xFF is also followed by 0x00.
- byte_ready held low: byte_out and byte_valid stay stable. The accumulator fills, then code_ready drops. No bits are lost or reordered.

Optional Feature:
JPEG_BSW_BYTE_COUNT_EN
- Defined: adds output port byte_count [31:0]. It counts every accepted output byte, including stuff bytes, clears on reset and on the S_DONE cycle, and wraps at 2^32.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package jpeg_pkg: state encodings (S_RUN, S_PAD, S_DRAIN, S_DONE), JPEG_STUFF_BYTE=8'h00, JPEG_MARKER_PREFIX=8'hFF, CODE_LEN_W=6.
- One natural sub-module, jpeg_bsw_out_slot: the byte output register with valid/ready hold and FF-detect/stuff_pending logic.
- The accumulator and FSM stay in the top module.

Test Plan:
1. Codes (3'b101, len 3) then (5'b11111, len 5), byte_ready=1 -> single byte 0xBF; no stuff byte.
2. Code 0xFF len 8, then 0x12 len 8 -> bytes 0xFF, 0x00, 0x12 in order.
3. Code 3'b010 len 3 with code_last=1 -> byte 0x5F, then flush_done pulses one cycle after its acceptance; code_ready returns high.
4. Code 4'b1111 len 4 with code_last=1 -> 0xFF then 0x00 (pad-generated stuffing), then flush_done.
5. Stream 20 random codes while byte_ready is low for 12 cycles -> byte_out held stable, code_ready deasserts, output bit sequence matches the reference packer model exactly after release.
6. Assert rst_n low mid-stream with byte_valid=1 -> byte_valid=0, code_ready=0 immediately. After release, first code (8'hA5, len 8) -> 0xA5 with no stale bits.
